// File: rtl/nv_slcg_en_ctrl_if.sv
// Clock-gate enable controller bus: activity/wake inputs,
// delay config and gate-cell enable/status outputs.
interface nv_slcg_en_ctrl_if #(
  parameter int DLY_W = 8,
  parameter int CNT_W = 16
);
  logic             slcg_busy;
  logic             slcg_wake_req;
  logic             dla_clk_ovr_on;
  logic             tmc2slcg_disable_clock_gating;
  logic [DLY_W-1:0] cfg_idle_dly;
  logic             slcg_en;
  logic             slcg_te;
  logic             slcg_wake_rdy;
  logic             slcg_gated;
  logic [CNT_W-1:0] slcg_gate_cnt;

  modport master (
    output slcg_busy, slcg_wake_req, dla_clk_ovr_on,
    output tmc2slcg_disable_clock_gating, cfg_idle_dly,
    input  slcg_en, slcg_te, slcg_wake_rdy,
    input  slcg_gated, slcg_gate_cnt
  );

  modport slave (
    input  slcg_busy, slcg_wake_req, dla_clk_ovr_on,
    input  tmc2slcg_disable_clock_gating, cfg_idle_dly,
    output slcg_en, slcg_te, slcg_wake_rdy,
    output slcg_gated, slcg_gate_cnt
  );
endinterface

// File: rtl/nv_slcg_en_ctrl.sv
// Second-level clock-gate enable controller: closes the
// gated clock after an idle delay, reopens on activity/wake.
module nv_slcg_en_ctrl #(
  parameter int DLY_W    = 8,
  parameter int WAKE_LAT = 2,
  parameter int CNT_W    = 16
) (
  input  logic nvdla_core_clk,
  input  logic nvdla_core_rst,
  nv_slcg_en_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN, IDLE_CNT, GATED, WAKE
  } state_t;

  localparam logic [3:0] WAKE_LD = 4'(WAKE_LAT - 1);

  state_t           state, state_nxt;
  logic [DLY_W-1:0] idle_cnt, idle_nxt;
  logic [3:0]       wake_cnt, wake_nxt;
  logic [CNT_W-1:0] gate_cnt;
  logic             gate_inc;
  logic             active;
  logic             en_q, rdy_q, gated_q;

  assign active = bus.slcg_busy | bus.slcg_wake_req
                | bus.dla_clk_ovr_on;

  // Next-state and counter updates; WAKE ignores inputs.
  always_comb begin
    state_nxt = state;
    idle_nxt  = idle_cnt;
    wake_nxt  = wake_cnt;
    gate_inc  = 1'b0;
    unique case (state)
      RUN: begin
        if (!active) begin
          state_nxt = IDLE_CNT;
          idle_nxt  = bus.cfg_idle_dly;
        end
      end
      IDLE_CNT: begin
        if (active) begin
          state_nxt = RUN;
        end else if (idle_cnt == '0) begin
          state_nxt = GATED;
          gate_inc  = 1'b1;
        end else begin
          idle_nxt = idle_cnt - 1'b1;
        end
      end
      GATED: begin
        if (active) begin
          state_nxt = WAKE;
          wake_nxt  = WAKE_LD;
        end
      end
      WAKE: begin
        if (wake_cnt == '0) state_nxt = RUN;
        else                wake_nxt  = wake_cnt - 1'b1;
      end
      default: state_nxt = RUN;
    endcase
  end

  // State, counters and registered outputs from next state.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      state    <= RUN;
      idle_cnt <= '0;
      wake_cnt <= '0;
      gate_cnt <= '0;
      en_q     <= 1'b1;
      rdy_q    <= 1'b1;
      gated_q  <= 1'b0;
    end else begin
      state    <= state_nxt;
      idle_cnt <= idle_nxt;
      wake_cnt <= wake_nxt;
      if (gate_inc && gate_cnt != '1)
        gate_cnt <= gate_cnt + 1'b1;
      en_q     <= (state_nxt != GATED);
      gated_q  <= (state_nxt == GATED);
      rdy_q    <= (state_nxt == RUN) ||
                  (state_nxt == IDLE_CNT);
    end
  end

  assign bus.slcg_en       = en_q;
  assign bus.slcg_wake_rdy = rdy_q;
  assign bus.slcg_gated    = gated_q;
  assign bus.slcg_gate_cnt = gate_cnt;
  assign bus.slcg_te       = bus.tmc2slcg_disable_clock_gating;

endmodule

// File: tb/tb_nv_slcg_en_ctrl.sv
// Directed bench for nv_slcg_en_ctrl: gating/wake latency,
// races, override/test mode, async reset, counter saturation.
module tb_nv_slcg_en_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   errs   = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  nv_slcg_en_ctrl_if #(.DLY_W(8), .CNT_W(16)) m ();
  nv_slcg_en_ctrl_if #(.DLY_W(8), .CNT_W(4))  s ();

  nv_slcg_en_ctrl #(.DLY_W(8), .WAKE_LAT(2), .CNT_W(16)) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .bus            (m.slave)
  );

  nv_slcg_en_ctrl #(.DLY_W(8), .WAKE_LAT(2), .CNT_W(4)) dut_s (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .bus            (s.slave)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bit dropped;
    rst = 1'b1;
    m.slcg_busy = 1'b0;
    m.slcg_wake_req = 1'b0;
    m.dla_clk_ovr_on = 1'b0;
    m.tmc2slcg_disable_clock_gating = 1'b0;
    m.cfg_idle_dly = 8'd3;
    s.slcg_busy = 1'b1;
    s.slcg_wake_req = 1'b0;
    s.dla_clk_ovr_on = 1'b0;
    s.tmc2slcg_disable_clock_gating = 1'b0;
    s.cfg_idle_dly = 8'd0;
    step(2);
    chk("rst_en", m.slcg_en, 1);
    chk("rst_rdy", m.slcg_wake_rdy, 1);
    chk("rst_gated", m.slcg_gated, 0);
    chk("rst_cnt", m.slcg_gate_cnt, 0);
    rst = 1'b0;

    // cfg=3, idle from edge 1: gate at edge 5
    for (int i = 1; i <= 4; i++) begin
      step(1);
      chk($sformatf("idle3_en_e%0d", i), m.slcg_en, 1);
    end
    step(1);
    chk("idle3_en_e5", m.slcg_en, 0);
    chk("idle3_gated", m.slcg_gated, 1);
    chk("idle3_cnt", m.slcg_gate_cnt, 1);
    chk("idle3_rdy", m.slcg_wake_rdy, 0);

    // wake request: en at M, rdy at M+2
    m.slcg_wake_req = 1'b1;
    step(1);
    chk("wake_en_M", m.slcg_en, 1);
    chk("wake_gated_M", m.slcg_gated, 0);
    chk("wake_rdy_M", m.slcg_wake_rdy, 0);
    step(1);
    chk("wake_rdy_M1", m.slcg_wake_rdy, 0);
    step(1);
    chk("wake_rdy_M2", m.slcg_wake_rdy, 1);
    m.slcg_wake_req = 1'b0;

    // cfg=5 count; cfg change mid-count ignored;
    // busy exactly at counter==0 wins
    m.cfg_idle_dly = 8'd5;
    step(1);
    m.cfg_idle_dly = 8'd0;
    dropped = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      if (m.slcg_en !== 1'b1) dropped = 1'b1;
    end
    m.slcg_busy = 1'b1;
    step(1);
    chk("race_en_hold", {31'b0, dropped}, 0);
    chk("race_en", m.slcg_en, 1);
    chk("race_rdy", m.slcg_wake_rdy, 1);
    chk("race_cnt", m.slcg_gate_cnt, 1);

    // full cfg=5 gating: en=0 at N+6
    m.cfg_idle_dly = 8'd5;
    m.slcg_busy = 1'b0;
    step(6);
    chk("idle5_en_N5", m.slcg_en, 1);
    step(1);
    chk("idle5_en_N6", m.slcg_en, 0);
    chk("idle5_cnt", m.slcg_gate_cnt, 2);

    // busy wake, then cfg=0 gates at N+1
    m.slcg_busy = 1'b1;
    step(1);
    chk("busy_wake_en", m.slcg_en, 1);
    step(3);
    m.cfg_idle_dly = 8'd0;
    m.slcg_busy = 1'b0;
    step(1);
    chk("idle0_en_N", m.slcg_en, 1);
    step(1);
    chk("idle0_en_N1", m.slcg_en, 0);
    chk("idle0_cnt", m.slcg_gate_cnt, 3);

    // override raised while gated, then held 100 cycles
    m.dla_clk_ovr_on = 1'b1;
    step(1);
    chk("ovr_wake_en", m.slcg_en, 1);
    dropped = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (m.slcg_en !== 1'b1) dropped = 1'b1;
    end
    chk("ovr_no_gate", {31'b0, dropped}, 0);
    chk("ovr_rdy", m.slcg_wake_rdy, 1);
    chk("ovr_cnt", m.slcg_gate_cnt, 3);

    // test-mode pass-through, no effect on enable
    #2 m.tmc2slcg_disable_clock_gating = 1'b1;
    #1 chk("te_hi", m.slcg_te, 1);
    chk("te_hi_en", m.slcg_en, 1);
    step(2);
    chk("te_hold_en", m.slcg_en, 1);
    #2 m.tmc2slcg_disable_clock_gating = 1'b0;
    #1 chk("te_lo", m.slcg_te, 0);
    step(1);
    m.dla_clk_ovr_on = 1'b0;

    // reset mid-WAKE
    step(2);
    chk("pre_wake_gated", m.slcg_gated, 1);
    m.slcg_wake_req = 1'b1;
    step(1);
    chk("mid_wake_rdy", m.slcg_wake_rdy, 0);
    #2 rst = 1'b1;
    #1;
    chk("rstw_en", m.slcg_en, 1);
    chk("rstw_rdy", m.slcg_wake_rdy, 1);
    chk("rstw_cnt", m.slcg_gate_cnt, 0);
    m.slcg_wake_req = 1'b0;
    #1 rst = 1'b0;

    // reset mid-GATED
    step(2);
    chk("regate_en", m.slcg_en, 0);
    chk("regate_cnt", m.slcg_gate_cnt, 1);
    #2 rst = 1'b1;
    #1;
    chk("rstg_en", m.slcg_en, 1);
    chk("rstg_rdy", m.slcg_wake_rdy, 1);
    chk("rstg_gated", m.slcg_gated, 0);
    chk("rstg_cnt", m.slcg_gate_cnt, 0);
    #1 rst = 1'b0;

    // saturation on 4-bit counter instance
    step(1);
    for (int i = 1; i <= 17; i++) begin
      s.slcg_busy = 1'b0;
      step(2);
      if (i == 14) chk("sat_14", s.slcg_gate_cnt, 14);
      if (i == 15) chk("sat_15", s.slcg_gate_cnt, 15);
      s.slcg_busy = 1'b1;
      step(3);
    end
    chk("sat_hold", s.slcg_gate_cnt, 15);
    chk("sat_rdy", s.slcg_wake_rdy, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/nv_slcg_en_ctrl.md
Name: nv_slcg_en_ctrl

Overview:
- Second-level clock-gate enable controller. Sits directly upstream of the latch-based integrated clock-gate cell and drives its functional enable (E) and test enable (TE) pins.
- Watches activity from the gated sub-unit and closes the clock after a programmable idle delay.
- Reopens the clock on activity or on a wake request, and tells requesters when the gated domain is clocked again.
- Runs entirely on the free-running core clock.

Parameters:
- DLY_W, 8, width of the idle-delay configuration and the idle counter.
- WAKE_LAT, 2, cycles the enable is held high in WAKE before ready is granted (legal range 1..15).
- CNT_W, 16, width of the saturating gate-event counter.

Ports:
- nvdla_core_clk  in  1  free-running core clock (ungated)
- nvdla_core_rst  in  1  reset, asynchronous, active-high
- slcg_busy  in  1  activity indication from the gated sub-unit
- slcg_wake_req  in  1  request that the gated domain be clocked
- dla_clk_ovr_on  in  1  override: keep the clock enabled
- tmc2slcg_disable_clock_gating  in  1  scan/test mode
- cfg_idle_dly  in  DLY_W  idle cycles tolerated before gating
- slcg_en  out  1  registered functional enable to the clock-gate cell E pin
- slcg_te  out  1  test enable to the clock-gate cell TE pin
- slcg_wake_rdy  out  1  gated domain is clocked; wake request accepted
- slcg_gated  out  1  status: clock currently gated
- slcg_gate_cnt  out  CNT_W  number of gating events, saturating

Behaviour:
- Interface: one clock, nvdla_core_clk. Reset nvdla_core_rst is asynchronous and active-high.
- Reset values (immediate, asynchronous):
  - state=RUN, slcg_en=1, slcg_wake_rdy=1, slcg_gated=0, slcg_gate_cnt=0
  - idle counter = 0, wake counter = 0
- slcg_te = tmc2slcg_disable_clock_gating, combinational pass-through. The state machine ignores it.
- "active" = slcg_busy | slcg_wake_req | dla_clk_ovr_on.
- State machine, evaluated at each posedge:
  - RUN:
    - if !active: go to IDLE_CNT and load the idle counter with cfg_idle_dly.
    - otherwise stay in RUN.
  - IDLE_CNT:
    - if active: go to RUN.
    - else if counter==0: go to GATED and increment slcg_gate_cnt (saturates at all-ones).
    - else: decrement counter.
  - GATED:
    - if active: go to WAKE and load the wake counter with WAKE_LAT-1.
    - otherwise stay.
  - WAKE:
    - inputs are ignored.
    - if counter==0: go to RUN.
    - else: decrement counter.
- Output registers (flop outputs, no combinational path to outputs):
  - slcg_en = (next_state != GATED)
  - slcg_gated = (next_state == GATED)
  - slcg_wake_rdy = (next_state == RUN || next_state == IDLE_CNT)
- Gating latency:
  - busy falls with all other inputs idle, first sampled low at edge N.
  - slcg_en goes low at edge N+cfg_idle_dly+1.
  - With cfg=0, slcg_en goes low at N+1.
- Wake latency:
  - active first sampled at edge M while GATED.
  - slcg_en goes high at M.
  - slcg_wake_rdy goes high at M+WAKE_LAT.
- cfg_idle_dly is sampled only on RUN->IDLE_CNT. Changing it mid-count has no effect on the current count.
- Simultaneous events:
  - An active input in the same cycle the idle counter hits 0 wins: go to RUN, no gating, no count increment.
  - Active in GATED always goes to WAKE, whichever input caused it.
- dla_clk_ovr_on held high: never gates. Raised while GATED: normal WAKE sequence.
- Reset mid-operation: slcg_en returns to 1 asynchronously. Counters clear. A pending wake is dropped and the requester sees slcg_wake_rdy=1 after reset.
- slcg_wake_req is level-based. The requester holds it until slcg_wake_rdy=1. The handshake completes in any cycle where both are 1.

Test Plan:
- Reset, then cfg=3 and all inputs low. Required: slcg_en=1 for edges 1..4, slcg_en=0 from edge 5, slcg_gated=1, slcg_gate_cnt=1.
- Gated, WAKE_LAT=2, slcg_wake_req raised at edge M. Required: slcg_en=1 at M, slcg_wake_rdy=0 at M+1, slcg_wake_rdy=1 at M+2, state RUN.
- cfg=5, busy pulsed high exactly at counter==0. Required: returns to RUN, slcg_en never drops, slcg_gate_cnt unchanged.
- Override plus test mode:
  - dla_clk_ovr_on=1 for 100 idle cycles: slcg_en stays 1.
  - tmc2slcg_disable_clock_gating toggled: slcg_te follows in the same cycle, slcg_en unaffected.
- nvdla_core_rst asserted mid-WAKE and mid-GATED. Required: slcg_en=1 and slcg_wake_rdy=1 immediately (before the next clock edge), slcg_gate_cnt=0.
- Force 0xFFFF gating events (cfg=0, alternating busy). Required: counter saturates at 0xFFFF and does not wrap.
